// File: rtl/iob_vexriscv_dbus_bridge.sv
// Registered bridge from the VexRiscv dBus cmd/rsp port to the IOb native bus.
// One outstanding IOb request; loads get a response, misaligned stores are dropped.
module iob_vexriscv_dbus_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dbus_cmd_valid,
    output logic                  dbus_cmd_ready,
    input  logic                  dbus_cmd_wr,
    input  logic [ADDR_W-1:0]     dbus_cmd_address,
    input  logic [DATA_W-1:0]     dbus_cmd_data,
    input  logic [1:0]            dbus_cmd_size,
    output logic                  dbus_rsp_ready,
    output logic                  dbus_rsp_error,
    output logic [DATA_W-1:0]     dbus_rsp_data,
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_ready,
    output logic                  wr_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    logic [1:0]          state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                wr_q;
    logic [3:0]          mask_q;
    logic [3:0]          mask;
    logic                misaligned;
    logic                accept;

    // ERR is the cycle the error response is presented; it is also free to
    // accept the next command, so an erroneous load is ready again at t+1.
    assign dbus_cmd_ready = (state != REQ);
    assign accept         = dbus_cmd_valid & dbus_cmd_ready;
    assign m_valid        = (state == REQ);
    assign m_address      = addr_q;
    assign m_wdata        = data_q;
    assign m_wstrb        = (m_valid && wr_q) ? mask_q : '0;

    always_comb begin
        mask       = 4'b1111;
        misaligned = 1'b0;
        case (dbus_cmd_size)
            2'd0: mask = 4'b0001 << dbus_cmd_address[1:0];
            2'd1: begin
                mask       = 4'b0011 << dbus_cmd_address[1:0];
                misaligned = dbus_cmd_address[0];
            end
            2'd2: misaligned = (dbus_cmd_address[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            data_q         <= '0;
            wr_q           <= 1'b0;
            mask_q         <= '0;
            dbus_rsp_ready <= 1'b0;
            dbus_rsp_error <= 1'b0;
            dbus_rsp_data  <= '0;
            wr_err         <= 1'b0;
        end else begin
            dbus_rsp_ready <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    state <= IDLE;
                    if (accept) begin
                        if (misaligned) begin
                            if (dbus_cmd_wr) begin
                                wr_err <= 1'b1;
                            end else begin
                                state          <= ERR;
                                dbus_rsp_ready <= 1'b1;
                                dbus_rsp_error <= 1'b1;
                                dbus_rsp_data  <= '0;
                            end
                        end else begin
                            state  <= REQ;
                            addr_q <= dbus_cmd_address;
                            data_q <= dbus_cmd_data;
                            wr_q   <= dbus_cmd_wr;
                            mask_q <= mask;
                        end
                    end
                end
                REQ: begin
                    if (m_ready) begin
                        state <= IDLE;
                        if (!wr_q) begin
                            dbus_rsp_ready <= 1'b1;
                            dbus_rsp_error <= 1'b0;
                            dbus_rsp_data  <= m_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
